// File: rtl/addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one external combinational adder/subtractor.
// Accepts one operation at a time, runs it through the shared unit and returns the result.
module addsub_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_sub,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]       resp_data,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic                   alu_s,
    input  logic [WIDTH-1:0]       alu_answer,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         grant_q, grant_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               op_s_q, op_s_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               gnt_found;
    logic [2:0]         gnt_idx;
    logic [3:0]         slot;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               sel_s;
    logic               resp_hit;

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        slot      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            slot = {1'b0, ptr_q} + 4'(k);
            if (slot >= 4'(N_REQ)) slot = slot - 4'(N_REQ);
            for (int i = 0; i < N_REQ; i++) begin
                if (!gnt_found && slot == 4'(i) && req_valid[i]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_s    = 1'b0;
        resp_hit = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == 3'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
                sel_s = req_sub[i];
            end
            if (grant_q == 3'(i) && resp_ready[i]) resp_hit = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_s_d   = op_s_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    op_s_d  = sel_s;
                    grant_d = gnt_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_answer;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_hit) begin
                    ptr_d   = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_s_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_s_q   <= op_s_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i]  = (state_q == IDLE) && gnt_found && (gnt_idx == 3'(i));
            resp_valid[i] = (state_q == RESP) && (grant_q == 3'(i));
        end
    end

    // Result is only presented while a response is pending.
    assign resp_data = (state_q == RESP) ? result_q : '0;
    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;
    assign alu_s     = op_s_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a behavioural stand-in for the shared adder/subtractor.
module tb_addsub_arbiter;

    localparam int N = 4;
    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_sub, resp_valid, resp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   resp_data, alu_a, alu_b, alu_answer;
    logic           alu_s, busy;
    logic [2:0]     grant_id;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign alu_answer = alu_s ? alu_a - alu_b : alu_a + alu_b;

    addsub_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_answer(alu_answer),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        int         r;
        logic [5:0] a;
        logic [5:0] b;
        logic       s;
        logic [5:0] e;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_op(input int r, input logic [5:0] a, input logic [5:0] b, input logic s);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_sub[r]      = s;
    endtask

    // Single-requester transaction, called at a negedge with the arbiter in IDLE.
    task automatic do_op(input int r, input logic [5:0] a, input logic [5:0] b,
                         input logic s, input logic [5:0] e, input string tag);
        set_op(r, a, b, s);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        #1;
        chk({tag, " req_ready"}, req_ready, 64'(4'b0001 << r));
        @(negedge clk);
        req_valid = '0;
        chk({tag, " alu_a"}, alu_a, a);
        chk({tag, " alu_b"}, alu_b, b);
        chk({tag, " alu_s"}, alu_s, s);
        chk({tag, " busy"}, busy, 1);
        chk({tag, " grant_id"}, grant_id, r);
        @(negedge clk);
        chk({tag, " resp_valid"}, resp_valid, 64'(4'b0001 << r));
        chk({tag, " resp_data"}, resp_data, e);
        resp_ready[r] = 1'b1;
        @(negedge clk);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle resp_valid"}, resp_valid, 0);
        resp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        int last;
        vecs[0] = '{0, 6'd63, 6'd46, 1'b1, 6'd17};
        vecs[1] = '{2, 6'd63, 6'd46, 1'b0, 6'd45};
        vecs[2] = '{1, 6'd0,  6'd1,  1'b1, 6'd63};
        vecs[3] = '{3, 6'd32, 6'd32, 1'b0, 6'd0};
        vecs[4] = '{1, 6'd10, 6'd20, 1'b0, 6'd30};
        vecs[5] = '{3, 6'd5,  6'd7,  1'b1, 6'd62};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; resp_ready = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst grant_id", grant_id, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst alu_a", alu_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++)
            do_op(vecs[v].r, vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].e, $sformatf("vec%0d", v));

        // All four valid with resp_ready high: strict rotation, one grant every 3 cycles.
        for (int i = 0; i < N; i++) set_op(i, 6'(i + 1), 6'd1, 1'b0);
        req_valid = 4'hF; resp_ready = 4'hF;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wt = 0;
            #1;
            while (req_ready == '0 && wt < 8) begin
                @(negedge clk); #1;
                wt++;
            end
            chk($sformatf("rr wait%0d", g), (wt < 8), 1);
            chk($sformatf("rr grant%0d", g), req_ready, 64'(4'b0001 << (g % 4)));
            if (g > 0) chk($sformatf("rr gap%0d", g), cyc - last, 3);
            last = cyc;
            @(negedge clk);
            if (g == 4) req_valid = '0;
        end
        @(negedge clk);
        chk("rr last resp", resp_valid, 4'b0001);
        @(negedge clk);
        resp_ready = '0;

        // ptr becomes 2; then 0 and 3 compete, 3 first; 1 arrives later and queues behind 0.
        do_op(1, 6'd3, 6'd4, 1'b0, 6'd7, "t4 req1");
        req_valid = 4'b1001;
        #1;
        chk("t4 grant3", req_ready, 4'b1000);
        @(negedge clk);
        chk("t4 grant_id3", grant_id, 3);
        req_valid = 4'b0011;
        @(negedge clk);
        resp_ready = 4'b1000;
        @(negedge clk);
        chk("t4 grant0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid  = 4'b0010;
        resp_ready = 4'b0001;
        @(negedge clk);
        chk("t4 early ready resp", resp_valid, 4'b0001);
        @(negedge clk);
        chk("t4 grant1", req_ready, 4'b0010);
        req_valid = '0; resp_ready = '0;
        @(negedge clk);

        // Response held off for 5 cycles while other requesters wait.
        set_op(1, 6'd50, 6'd7, 1'b1);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid  = 4'b0101;
        resp_ready = 4'b1101;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d resp_valid", c), resp_valid, 4'b0010);
            chk($sformatf("hold%0d resp_data", c), resp_data, 43);
            chk($sformatf("hold%0d busy", c), busy, 1);
            chk($sformatf("hold%0d req_ready", c), req_ready, 0);
            @(negedge clk);
        end
        resp_ready[1] = 1'b1;
        @(negedge clk);
        chk("hold release busy", busy, 0);
        chk("hold release grant2", req_ready, 4'b0100);
        req_valid = '0; resp_ready = '0;
        @(negedge clk);

        // Asynchronous reset in the middle of EXEC.
        set_op(3, 6'd1, 6'd2, 1'b0);
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        chk("arst pre grant_id", grant_id, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst req_ready", req_ready, 0);
        chk("arst resp_valid", resp_valid, 0);
        chk("arst resp_data", resp_data, 0);
        chk("arst alu_a", alu_a, 0);
        chk("arst alu_b", alu_b, 0);
        chk("arst alu_s", alu_s, 0);
        chk("arst busy", busy, 0);
        chk("arst grant_id", grant_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("arst after%0d resp_valid", c), resp_valid, 0);
            chk($sformatf("arst after%0d busy", c), busy, 0);
        end
        set_op(1, 6'd9, 6'd4, 1'b1);
        req_valid = 4'b1010;
        #1;
        chk("arst ptr0 grant1", req_ready, 4'b0010);
        @(negedge clk);
        req_valid  = '0;
        resp_ready = 4'b0010;
        @(negedge clk);
        chk("arst resume data", resp_data, 5);
        @(negedge clk);
        resp_ready = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one combinational 6-bit adder/subtractor among several requesters. It accepts one operation at a time over a valid/ready handshake and drives the shared unit's A, B and S inputs from registered operands. It captures the unit's ANSWER and returns it to the granted requester over a per-requester response handshake. It sits between the client blocks and the single `Adder_Subtractor` instance, which stays external.

## Interface
- N_REQ, default 4: number of requesters, range 2..8.
- WIDTH, default 6: operand and result width; must match the shared adder/subtractor.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  requester i presents an operation.
- req_ready  output  N_REQ  one-hot, combinational; the operation is accepted on a clock edge where valid[i] & ready[i].
- req_a  input  N_REQ*WIDTH  operand A of requester i, in bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand B of requester i, packed the same way.
- req_sub  input  N_REQ  operation select for requester i: 1 = A−B, 0 = A+B.
- resp_valid  output  N_REQ  one-hot; result is ready for requester i.
- resp_ready  input  N_REQ  requester i consumes the result.
- resp_data  output  WIDTH  result for the requester flagged in resp_valid.
- alu_a  output  WIDTH  drives the shared unit's A input.
- alu_b  output  WIDTH  drives the shared unit's B input.
- alu_s  output  1  drives the shared unit's S input.
- alu_answer  input  WIDTH  ANSWER from the shared unit.
- busy  output  1  high whenever the state is not IDLE.
- grant_id  output  3  index of the current or most recent grant.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - If any req_valid is high, select a grant by round-robin: scan from index ptr upward, modulo N_REQ; the first valid index wins.
  - Assert req_ready[grant] combinationally, only in IDLE.
  - On the edge: latch req_a, req_b and req_sub of the grant into op_a, op_b, op_s; latch grant into grant_id; go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC**
  - alu_a, alu_b and alu_s are driven continuously from op_a, op_b and op_s.
  - On the edge: result_q <= alu_answer; go to RESP.
- **RESP**
  - resp_valid[grant_id] = 1 and resp_data = result_q.
  - On an edge with resp_ready[grant_id]: set ptr <= (grant_id+1) mod N_REQ and go to IDLE.
  - Otherwise hold the response; result_q and the operand registers do not change.
- Arithmetic is performed by the external unit, modulo 2^WIDTH, two's complement. No carry or overflow is reported. The arbiter does not modify the value.
- A requester must hold req_valid, operands and req_sub stable until accepted. Dropping valid before acceptance is legal; the scan re-evaluates each cycle.
- resp_ready on a non-granted index is ignored.
- req_ready is never asserted outside IDLE; there is no request queueing.
- Reset (asynchronous, any state): state=IDLE, ptr=0, grant_id=0, op_a=op_b=0, op_s=0, result_q=0.
  - As a result, all outputs are 0: req_ready, resp_valid, resp_data, alu_a, alu_b, alu_s, busy, grant_id.
  - An in-flight operation is discarded and produces no response.

## Timing
- Accept at edge T0. EXEC occupies cycle T0→T1. resp_valid is high from T1 until the resp_ready edge.
- Minimum spacing between accepts is 3 cycles: accept, EXEC, and a RESP consumed on its first cycle, then IDLE.
- The pointer updates only when a response completes. A requester that stays valid is served within N_REQ grants.
- Several simultaneous valids: exactly one grant; the others wait in IDLE of a later pass.
- When ptr=N_REQ−1, the scan wraps to 0.
- resp_ready held high before resp_valid rises causes completion in the first RESP cycle.

## Test plan
1. Requester 0 only: a=63, b=46, sub=1. Required: accepted on the first IDLE edge; resp_valid[0] high 1 cycle later with resp_data=6'b010001 (17); alu_s=1 during EXEC.
2. Requester 2: a=63, b=46, sub=0. Required: resp_data=45 (109 mod 64); alu_s=0.
3. All four valid continuously, resp_ready tied high. Required: grants in order 0,1,2,3,0, one response every 3 cycles.
4. After requester 1 completes (ptr=2), requesters 0 and 3 become valid. Required: 3 is granted before 0; requester 1 going valid later waits behind 0.
5. resp_ready[1] held low 5 cycles in RESP while others are valid. Required: resp_data stable, busy=1, no req_ready asserted; release -> IDLE next cycle.
6. rst_n pulsed low mid-EXEC (asynchronously, between edges). Required: all outputs 0 immediately; no resp_valid after release; the next grant starts from index 0.
